hbridge_pwm_array: RTL and testbench
====================================

Name: hbridge_pwm_array

Overview:
Multi-channel H-bridge PWM driver. Generalises the single-bridge controller to NUM_CH bridges sharing one period counter.
- Per-channel direction/enable state machine with enforced dead time.
- Duty updates are glitch-free: applied only at the PWM period boundary.
- Sits between the register/command interface and the FET gate drive pins.

Parameters:
- NUM_CH, 4, number of H-bridges
- DC_WIDTH, 10, duty-cycle word width; duty resolution 2^DC_WIDTH
- PERIOD_POW, 14, period counter width; period = 2^PERIOD_POW clk cycles; must be >= DC_WIDTH
- DEAD_TIME, 256, clk cycles with outputs held at 0 after any enable/direction change; must be >= 1
- MAX_DC, 1000, duty ceiling; applied duty saturates at this value
- RAMP_STEP, 1, max change of applied duty per period (only used with DUTY_RAMP_EN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- dir  in  NUM_CH  per-channel direction, 1 = forward
- on  in  NUM_CH  per-channel enable
- duty_cycle  in  NUM_CH*DC_WIDTH  target duty, channel c at [c*DC_WIDTH +: DC_WIDTH]
- out  out  4*NUM_CH  gate drive, channel c at [4c+3:4c]
- driving  out  NUM_CH  channel c FSM in DRIVE
- period_start  out  1  one-cycle pulse when the period counter is 0

Behaviour:
Reset (async assert, sync release):
- counter = 0, out = 0, driving = 0, period_start = 0.
- All FSMs in OFF; latched dir = 0; applied duty = 0.

Shared period counter:
- Free-running, PERIOD_POW bits, +1 per clk, wraps from all-ones to 0.
- phase = counter[PERIOD_POW-1 -: DC_WIDTH].
- Boundary = cycle where counter is all-ones.

Duty handling:
- At each boundary, per channel: applied <= min(duty_cycle[c], MAX_DC).
- Mid-period changes to duty_cycle have no effect until the next boundary.

Per-channel FSM, states OFF, DEAD, DRIVE, evaluated every clk:
- OFF: on=1 -> DEAD, dead_cnt = 0, latched dir = dir.
- DEAD: dead_cnt increments.
  - on=0 -> OFF.
  - dir != latched dir -> stay in DEAD, dead_cnt = 0, latch new dir.
  - dead_cnt == DEAD_TIME-1 with no change -> DRIVE.
- DRIVE:
  - on=0 -> OFF.
  - dir != latched dir -> DEAD, dead_cnt = 0, latch new dir.
- Simultaneous on=0 and dir change resolves to OFF.

Outputs (all registered, 1 clk latency from state/counter):
- pattern = 4'b1001 if latched dir = 1, else 4'b0110.
- out[c] = pattern when state == DRIVE and phase < applied; otherwise 4'b0000.
- Duty 0 gives constant 0. Duty >= MAX_DC is capped at a high time of MAX_DC*2^(PERIOD_POW-DC_WIDTH) cycles.
- No cycle may drive both legs of one side: 4'b1001 and 4'b0110 are never adjacent in time for a channel; at least DEAD_TIME zero cycles always separate them.
- driving[c] is a registered copy of (state == DRIVE).
- period_start is registered; high the cycle after the counter is 0.
- Channels are fully independent apart from sharing the counter.
- Reset mid-period or mid-dead-time immediately zeroes all outputs.

Optional Feature:
Macro DUTY_RAMP_EN.
- Defined:
  - At each boundary, applied moves toward min(target, MAX_DC) by at most RAMP_STEP, up or down, without overshoot.
  - Entering OFF or DEAD forces applied = 0, so every start or reversal ramps up from 0.
- Undefined:
  - applied jumps to the saturated target at the boundary.
  - Applied duty is not cleared on OFF/DEAD.
  - RAMP_STEP is unused.

Test Plan:
Bench parameters: NUM_CH=2, DC_WIDTH=4, PERIOD_POW=6, DEAD_TIME=8, MAX_DC=14, macro undefined unless noted.
1. Release reset; on[0]=1, dir[0]=1, duty=8 -> out[3:0]=0 for 8 cycles of DEAD; from the first full period after that, out[3:0]=1001 for 32 of 64 cycles starting at counter 0, 0 otherwise.
2. Channel 0 driving at duty 8; flip dir[0] to 0 -> out[3:0]=0 for >=8 cycles; then 0110 pattern; never 1001 directly followed by 0110.
3. Change duty 8 -> 4 at counter 20 -> current period keeps a 32-cycle high time; next period has 16 cycles high.
4. Apply duty 15 -> high time 56 cycles per period (MAX_DC cap); duty 0 -> out stays 0 while driving=1.
5. Assert reset_n=0 mid-high-pulse -> out=0 in the same cycle (async); after release, FSM in OFF and dead time re-enforced.
6. DUTY_RAMP_EN defined, RAMP_STEP=1, on from OFF with duty 4 -> applied 1,2,3,4 over four successive periods (high time 4,8,12,16 cycles); dir flip resets the ramp to 0.

Source files
------------

// File: rtl/hbridge_pwm_array.sv
// -----------------------------------------------------------------------------
// hbridge_pwm_array
// Multi-channel H-bridge PWM driver. NUM_CH bridges share one free-running
// period counter; each channel has its own OFF/DEAD/DRIVE state machine that
// keeps the gate outputs at zero for DEAD_TIME cycles after any enable or
// direction change. Duty updates take effect only at the period boundary.
//
// Optional feature: define DUTY_RAMP_EN to slew the applied duty by at most
// RAMP_STEP per period, restarting from 0 whenever a channel is off or in
// dead time.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   dir          in   [NUM_CH]           per-channel direction, 1 = forward
//   on           in   [NUM_CH]           per-channel enable
//   duty_cycle   in   [NUM_CH*DC_WIDTH]  target duty, channel c at [c*DC_WIDTH +: DC_WIDTH]
//   out          out  [4*NUM_CH]         gate drive, channel c at [4c+3:4c]
//   driving      out  [NUM_CH]           channel c state machine is in DRIVE
//   period_start out  1                  pulse the cycle after the counter is 0
// -----------------------------------------------------------------------------
module hbridge_pwm_array #(
    parameter int NUM_CH     = 4,
    parameter int DC_WIDTH   = 10,
    parameter int PERIOD_POW = 14,
    parameter int DEAD_TIME  = 256,
    parameter int MAX_DC     = 1000,
    parameter int RAMP_STEP  = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            dir,
    input  logic [NUM_CH-1:0]            on,
    input  logic [NUM_CH*DC_WIDTH-1:0]   duty_cycle,
    output logic [4*NUM_CH-1:0]          out,
    output logic [NUM_CH-1:0]            driving,
    output logic                         period_start
);

    if (PERIOD_POW < DC_WIDTH || DEAD_TIME < 1 || RAMP_STEP < 0) begin : g_bad_params
        $error("hbridge_pwm_array: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DEAD,
        ST_DRIVE
    } state_t;

    localparam int                  DT_W    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [DT_W-1:0]     DT_LAST = DT_W'(DEAD_TIME - 1);
    localparam int                  DC_ALL  = (1 << DC_WIDTH) - 1;
    // Ceiling clipped to what the duty word can represent.
    localparam logic [DC_WIDTH-1:0] DC_CAP  = DC_WIDTH'((MAX_DC > DC_ALL) ? DC_ALL : MAX_DC);

    logic [PERIOD_POW-1:0] r_cnt;
    logic                  r_period_start;
    logic [DC_WIDTH-1:0]   w_phase;
    logic                  w_boundary;

    assign w_phase      = r_cnt[PERIOD_POW-1 -: DC_WIDTH];
    assign w_boundary   = &r_cnt;
    assign period_start = r_period_start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= r_cnt + 1'b1;
            r_period_start <= (r_cnt == '0);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t              r_state;
        logic                r_ldir;
        logic [DT_W-1:0]     r_dead_cnt;
        logic [DC_WIDTH-1:0] r_applied;
        logic [3:0]          r_out;
        logic                r_drv;
        logic [DC_WIDTH-1:0] w_target;
        logic [DC_WIDTH-1:0] w_sat;

        assign w_target = duty_cycle[c*DC_WIDTH +: DC_WIDTH];
        assign w_sat    = (w_target > DC_CAP) ? DC_CAP : w_target;

`ifdef DUTY_RAMP_EN
        localparam logic [DC_WIDTH-1:0] STEP_N = DC_WIDTH'((RAMP_STEP > DC_ALL) ? DC_ALL : RAMP_STEP);
        logic [DC_WIDTH-1:0] w_ramp;
        logic                w_hold_zero;

        // Applied duty is pinned to 0 unless the channel stays in DRIVE.
        assign w_hold_zero = (r_state != ST_DRIVE) || !on[c] || (dir[c] != r_ldir);

        // NOTE: combinational outputs get a default first so no path leaves
        // them unassigned (which would infer a latch).
        always_comb begin
            w_ramp = r_applied;
            if (w_sat > r_applied) begin
                w_ramp = ((w_sat - r_applied) > STEP_N) ? r_applied + STEP_N : w_sat;
            end else if (w_sat < r_applied) begin
                w_ramp = ((r_applied - w_sat) > STEP_N) ? r_applied - STEP_N : w_sat;
            end
        end
`endif

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state    <= ST_OFF;
                r_ldir     <= 1'b0;
                r_dead_cnt <= '0;
                r_applied  <= '0;
                r_out      <= 4'b0000;
                r_drv      <= 1'b0;
            end else begin
                // Outputs are decoded from the current state, so the pattern
                // seen on the pins always matches the direction latched while
                // in DRIVE; the cycle after leaving DRIVE is already zero.
                r_out <= (r_state == ST_DRIVE && w_phase < r_applied)
                         ? (r_ldir ? 4'b1001 : 4'b0110) : 4'b0000;
                r_drv <= (r_state == ST_DRIVE);

`ifdef DUTY_RAMP_EN
                if (w_hold_zero) begin
                    r_applied <= '0;
                end else if (w_boundary) begin
                    r_applied <= w_ramp;
                end
`else
                if (w_boundary) begin
                    r_applied <= w_sat;
                end
`endif

                case (r_state)
                    ST_OFF: begin
                        if (on[c]) begin
                            r_state    <= ST_DEAD;
                            r_dead_cnt <= '0;
                            r_ldir     <= dir[c];
                        end
                    end
                    ST_DEAD: begin
                        // Disable wins over a simultaneous direction change.
                        if (!on[c]) begin
                            r_state <= ST_OFF;
                        end else if (dir[c] != r_ldir) begin
                            r_dead_cnt <= '0;
                            r_ldir     <= dir[c];
                        end else if (r_dead_cnt == DT_LAST) begin
                            r_state <= ST_DRIVE;
                        end else begin
                            r_dead_cnt <= r_dead_cnt + 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (!on[c]) begin
                            r_state <= ST_OFF;
                        end else if (dir[c] != r_ldir) begin
                            r_state    <= ST_DEAD;
                            r_dead_cnt <= '0;
                            r_ldir     <= dir[c];
                        end
                    end
                    default: r_state <= ST_OFF;
                endcase
            end
        end

        assign out[4*c +: 4] = r_out;
        assign driving[c]    = r_drv;
    end

endmodule

// File: tb/tb_hbridge_pwm_array.sv
// -----------------------------------------------------------------------------
// tb_hbridge_pwm_array
// Self-checking bench for hbridge_pwm_array (NUM_CH=2, DC_WIDTH=4,
// PERIOD_POW=6, DEAD_TIME=8, MAX_DC=14, DUTY_RAMP_EN undefined).
// A cycle-level reference model (period index arithmetic plus a per-channel
// "dead cycles remaining" countdown) is compared against every output on
// every clock; on top of that, per-period high-time and pattern checks are
// driven from a vector table and a few hand-written corner sequences.
// -----------------------------------------------------------------------------
module tb_hbridge_pwm_array;

    localparam int NUM_CH     = 2;
    localparam int DC_WIDTH   = 4;
    localparam int PERIOD_POW = 6;
    localparam int DEAD_TIME  = 8;
    localparam int MAX_DC     = 14;
    localparam int RAMP_STEP  = 1;
    localparam int PERIOD     = 1 << PERIOD_POW;
    localparam int SUB        = 1 << (PERIOD_POW - DC_WIDTH);

    logic                       clk;
    logic                       reset_n;
    logic [NUM_CH-1:0]          dir;
    logic [NUM_CH-1:0]          on;
    logic [NUM_CH*DC_WIDTH-1:0] duty_cycle;
    logic [4*NUM_CH-1:0]        out;
    logic [NUM_CH-1:0]          driving;
    logic                       period_start;

    hbridge_pwm_array #(
        .NUM_CH     (NUM_CH),
        .DC_WIDTH   (DC_WIDTH),
        .PERIOD_POW (PERIOD_POW),
        .DEAD_TIME  (DEAD_TIME),
        .MAX_DC     (MAX_DC),
        .RAMP_STEP  (RAMP_STEP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dir          (dir),
        .on           (on),
        .duty_cycle   (duty_cycle),
        .out          (out),
        .driving      (driving),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cnt;
    bit          m_active   [NUM_CH];
    bit          m_ldir     [NUM_CH];
    int          m_dead_left[NUM_CH];
    int          m_applied  [NUM_CH];
    logic [7:0]  m_out;
    logic [1:0]  m_drv;
    logic        m_ps;

    // Dead-time adjacency monitor on the DUT pins.
    logic [3:0]  last_pat[NUM_CH];
    int          zero_run[NUM_CH];
    int          adj_viol = 0;

    function automatic void reset_model();
        m_cnt = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_active[c]    = 1'b0;
            m_ldir[c]      = 1'b0;
            m_dead_left[c] = 0;
            m_applied[c]   = 0;
        end
        m_out = '0;
        m_drv = '0;
        m_ps  = 1'b0;
    endfunction

    function automatic int sat_target(input int c);
        int t;
        t = int'(duty_cycle[c*DC_WIDTH +: DC_WIDTH]);
        return (t > MAX_DC) ? MAX_DC : t;
    endfunction

    // Advance the model by one clock edge, using the inputs present at it.
    function automatic void model_edge();
        logic [7:0] n_out;
        logic [1:0] n_drv;
        bit         drive;
        n_out = '0;
        n_drv = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            drive = m_active[c] && (m_dead_left[c] == 0);
            n_drv[c] = drive;
            if (drive && (m_cnt / SUB) < m_applied[c])
                n_out[4*c +: 4] = m_ldir[c] ? 4'b1001 : 4'b0110;
        end
        m_ps = (m_cnt == 0);
        if (m_cnt == PERIOD - 1)
            for (int c = 0; c < NUM_CH; c++) m_applied[c] = sat_target(c);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!on[c]) begin
                m_active[c] = 1'b0;
            end else if (!m_active[c] || dir[c] != m_ldir[c]) begin
                m_active[c]    = 1'b1;
                m_ldir[c]      = dir[c];
                m_dead_left[c] = DEAD_TIME;
            end else if (m_dead_left[c] > 0) begin
                m_dead_left[c]--;
            end
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        m_out = n_out;
        m_drv = n_drv;
    endfunction

    // One clock: model at the rising edge, compare on the falling edge.
    task automatic step();
        logic [3:0] p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out", out, m_out);
        check("driving", driving, m_drv);
        check("period_start", period_start, m_ps);
        for (int c = 0; c < NUM_CH; c++) begin
            p = out[4*c +: 4];
            if (p != 4'b0000) begin
                if (last_pat[c] != 4'b0000 && p != last_pat[c] && zero_run[c] < DEAD_TIME)
                    adj_viol++;
                last_pat[c] = p;
                zero_run[c] = 0;
            end else begin
                zero_run[c]++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the next edge processes counter value 0.
    task automatic align();
        for (int i = 0; i < PERIOD && m_cnt != 0; i++) step();
    endtask

    // Count high cycles and the observed pattern over one aligned period.
    task automatic measure(output int h0, output int h1, output logic [3:0] p0, output logic [3:0] p1);
        align();
        h0 = 0; h1 = 0; p0 = '0; p1 = '0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            if (out[3:0] != 0) begin h0++; p0 = out[3:0]; end
            if (out[7:4] != 0) begin h1++; p1 = out[7:4]; end
        end
    endtask

    // Edges from now until driving[ch] is seen high (bounded).
    task automatic edges_to_drive(input int ch, output int k);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            k++;
            if (driving[ch]) break;
        end
    endtask

    typedef struct {
        logic [1:0] on_v;
        logic [1:0] dir_v;
        logic [3:0] d0;
        logic [3:0] d1;
        int         h0;
        int         h1;
        logic [3:0] p0;
        logic [3:0] p1;
        logic [1:0] drv;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         h0, h1, k;
        logic [3:0] p0, p1;

        tbl[0] = '{2'b11, 2'b00, 4'd15, 4'd8,  56, 32, 4'b0110, 4'b0110, 2'b11};
        tbl[1] = '{2'b11, 2'b10, 4'd0,  4'd3,   0, 12, 4'b0000, 4'b1001, 2'b11};
        tbl[2] = '{2'b11, 2'b11, 4'd14, 4'd15, 56, 56, 4'b1001, 4'b1001, 2'b11};
        tbl[3] = '{2'b01, 2'b01, 4'd1,  4'd9,   4,  0, 4'b1001, 4'b0000, 2'b01};
        tbl[4] = '{2'b10, 2'b00, 4'd5,  4'd13,  0, 52, 4'b0000, 4'b0110, 2'b10};
        tbl[5] = '{2'b11, 2'b00, 4'd7,  4'd2,  28,  8, 4'b0110, 4'b0110, 2'b11};

        for (int c = 0; c < NUM_CH; c++) begin
            last_pat[c] = '0;
            zero_run[c] = 0;
        end

        // Reset state
        reset_n = 1'b0; on = '0; dir = '0; duty_cycle = '0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_driving", driving, 2'b00);
        check("rst_period_start", period_start, 1'b0);
        reset_n = 1'b1;
        run(5);

        // Start from OFF: dead time then 50% forward drive
        on[0] = 1'b1; dir[0] = 1'b1; duty_cycle[3:0] = 4'd8;
        edges_to_drive(0, k);
        check("start_dead_edges", k, DEAD_TIME + 2);
        measure(h0, h1, p0, p1);
        check("t1_high", h0, 32);
        check("t1_pattern", p0, 4'b1001);

        // Reversal: dead gap then reverse pattern
        dir[0] = 1'b0;
        measure(h0, h1, p0, p1);
        measure(h0, h1, p0, p1);
        check("rev_high", h0, 32);
        check("rev_pattern", p0, 4'b0110);

        // Mid-period duty change only lands at the boundary
        align();
        h0 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 20) duty_cycle[3:0] = 4'd4;
            step();
            if (out[3:0] != 0) h0++;
        end
        check("midchg_cur_high", h0, 32);
        measure(h0, h1, p0, p1);
        check("midchg_next_high", h0, 16);

        // Vector table
        foreach (tbl[i]) begin
            on = tbl[i].on_v; dir = tbl[i].dir_v;
            duty_cycle = {tbl[i].d1, tbl[i].d0};
            run(2 * PERIOD);
            measure(h0, h1, p0, p1);
            check($sformatf("vec%0d_high0", i), h0, tbl[i].h0);
            check($sformatf("vec%0d_high1", i), h1, tbl[i].h1);
            check($sformatf("vec%0d_pat0", i), p0, tbl[i].p0);
            check($sformatf("vec%0d_pat1", i), p1, tbl[i].p1);
            check($sformatf("vec%0d_driving", i), driving, tbl[i].drv);
        end

        // Asynchronous reset in the middle of a high pulse
        k = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (out[3:0] != 0) break;
            step();
            k++;
        end
        check("pulse_found", (out[3:0] != 0), 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out", out, 8'h00);
        check("async_rst_driving", driving, 2'b00);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        check("held_rst_out", out, 8'h00);
        reset_n = 1'b1;
        edges_to_drive(0, k);
        check("post_rst_dead_edges", k, DEAD_TIME + 2);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(15, 0) == 0) on[c]  = ~on[c];
                if ($urandom_range(15, 0) == 0) dir[c] = ~dir[c];
                if ($urandom_range(31, 0) == 0)
                    duty_cycle[c*DC_WIDTH +: DC_WIDTH] = DC_WIDTH'($urandom_range(15, 0));
            end
            step();
        end

        check("no_adjacent_legs", adj_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
